// File: rtl/itype_stim_sequencer.sv
// Stimulus sequencer for the sodor5 I-type co-simulation harness: optional LFSR register-file
// init (REGFILE_INIT_EN), then NOP warm-up, a random OP-IMM stream and a NOP drain.
module itype_stim_sequencer #(
    parameter int WARMUP_CYCLES = 2,
    parameter int DRAIN_CYCLES  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic [15:0] num_instr,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        rf_init_we,
    output logic [4:0]  rf_init_addr,
    output logic [31:0] rf_init_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] issued_count
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [7:0]  WARMUP_END = 8'(WARMUP_CYCLES - 1);
    localparam logic [7:0]  DRAIN_END  = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef REGFILE_INIT_EN
        S_INIT,
`endif
        S_WARMUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Shift-immediate encodings are masked so the core never sees an illegal shamt.
    function automatic logic [31:0] itype_word(input logic [31:0] l);
        logic [11:0] imm;
        imm = l[31:20];
        if (l[14:12] == 3'd5) imm = imm & 12'h41F;
        if (l[14:12] == 3'd1) imm = imm & 12'h01F;
        return {imm, l[19:15], l[14:12], l[11:7], 7'b0010011};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] num_q, num_d;
    logic [15:0] issued_q, issued_d;
    logic [7:0]  phase_q, phase_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fire;

`ifdef REGFILE_INIT_EN
    logic [4:0]  init_cnt_q, init_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;
`endif

    assign fire = instr_valid_q && instr_ready;

    always_comb begin
        // NOTE: every *_d defaults to its flop so no path through the case infers a latch.
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        num_d         = num_q;
        issued_d      = issued_q;
        phase_d       = phase_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        done_d        = done_q;
`ifdef REGFILE_INIT_EN
        init_cnt_d    = init_cnt_q;
        rf_we_d       = 1'b0;
        rf_addr_d     = rf_addr_q;
        rf_data_d     = rf_data_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d        = (seed == 32'h0) ? 32'h1 : seed;
                    num_d         = num_instr;
                    issued_d      = 16'h0;
                    phase_d       = 8'h0;
                    done_d        = 1'b0;
                    instr_valid_d = 1'b0;
                    instr_d       = NOP;
`ifdef REGFILE_INIT_EN
                    init_cnt_d    = 5'd0;
                    state_d       = S_INIT;
`else
                    state_d       = S_WARMUP;
`endif
                end
            end
`ifdef REGFILE_INIT_EN
            S_INIT: begin
                rf_we_d    = 1'b1;
                rf_addr_d  = init_cnt_q;
                rf_data_d  = lfsr_q;
                lfsr_d     = lfsr_step(lfsr_q);
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == 5'd31) state_d = S_WARMUP;
            end
`endif
            S_WARMUP: begin
                // Entered with valid low: the first edge only presents the first NOP.
                if (!instr_valid_q) begin
                    instr_valid_d = 1'b1;
                    instr_d       = NOP;
                end else if (fire) begin
                    phase_d = phase_q + 8'd1;
                    if (phase_q == WARMUP_END) begin
                        phase_d = 8'h0;
                        if (num_q == 16'h0) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_RUN;
                            instr_d = itype_word(lfsr_q);
                        end
                    end
                end
            end
            S_RUN: begin
                if (fire) begin
                    issued_d = issued_q + 16'd1;
                    lfsr_d   = lfsr_step(lfsr_q);
                    if (issued_q == num_q - 16'd1) begin
                        state_d = S_DRAIN;
                        instr_d = NOP;
                    end else begin
                        instr_d = itype_word(lfsr_step(lfsr_q));
                    end
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    phase_d = phase_q + 8'd1;
                    if (phase_q == DRAIN_END) begin
                        phase_d       = 8'h0;
                        state_d       = S_DONE;
                        instr_valid_d = 1'b0;
                        done_d        = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // NOTE: sequential state is only ever assigned with <= so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 32'h1;
            num_q         <= 16'h0;
            issued_q      <= 16'h0;
            phase_q       <= 8'h0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef REGFILE_INIT_EN
            init_cnt_q    <= 5'd0;
            rf_we_q       <= 1'b0;
            rf_addr_q     <= 5'd0;
            rf_data_q     <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            num_q         <= num_d;
            issued_q      <= issued_d;
            phase_q       <= phase_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef REGFILE_INIT_EN
            init_cnt_q    <= init_cnt_d;
            rf_we_q       <= rf_we_d;
            rf_addr_q     <= rf_addr_d;
            rf_data_q     <= rf_data_d;
`endif
        end
    end

    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = issued_q;
`ifdef REGFILE_INIT_EN
    assign rf_init_we   = rf_we_q;
    assign rf_init_addr = rf_addr_q;
    assign rf_init_data = rf_data_q;
`else
    assign rf_init_we   = 1'b0;
    assign rf_init_addr = 5'd0;
    assign rf_init_data = 32'h0;
`endif

endmodule

// File: tb/tb_itype_stim_sequencer.sv
// Scoreboard bench for itype_stim_sequencer: expected init writes and instruction beats are
// queued when a run is started and popped as the DUT produces them. Honours REGFILE_INIT_EN.
module tb_itype_stim_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int W = 2;
    localparam int D = 5;
`ifdef REGFILE_INIT_EN
    localparam int INIT_LEN = 32;
`else
    localparam int INIT_LEN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed;
    logic [15:0] num_instr;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        rf_init_we;
    logic [4:0]  rf_init_addr;
    logic [31:0] rf_init_data;
    logic        busy;
    logic        done;
    logic [15:0] issued_count;

    itype_stim_sequencer #(.WARMUP_CYCLES(W), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .num_instr(num_instr),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
        .rf_init_we(rf_init_we), .rf_init_addr(rf_init_addr), .rf_init_data(rf_init_data),
        .busy(busy), .done(done), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc;
    int          beat_idx;
    int          nop_cnt;
    int          nonnop_cnt;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    logic [31:0] first_run_word;
    logic [31:0] init_log [0:3];
    logic [31:0] exp_q [$];
    logic [36:0] init_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Inverse step: the tap word has bit 31 set, so bit 31 of the result reveals the shifted-out bit.
    function automatic logic [31:0] lfsr_prev(input logic [31:0] n);
        logic b;
        b = n[31];
        return ((n ^ (b ? 32'h8020_0003 : 32'h0)) << 1) | {31'b0, b};
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] l);
        logic [11:0] imm;
        logic [2:0]  f3;
        imm = l[31:20];
        f3  = l[14:12];
        if (f3 == 3'd5) imm = imm & 12'h41F;
        else if (f3 == 3'd1) imm = imm & 12'h01F;
        return {imm, l[19:15], f3, l[11:7], 7'h13};
    endfunction

    task automatic push_expected(input logic [31:0] s, input logic [15:0] n);
        logic [31:0] l;
        l = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < INIT_LEN; i++) begin
            init_q.push_back({i[4:0], l});
            l = lfsr_next(l);
        end
        for (int i = 0; i < W; i++) exp_q.push_back(NOP);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(model_word(l));
            l = lfsr_next(l);
        end
        for (int i = 0; i < D; i++) exp_q.push_back(NOP);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_run(input logic [31:0] s, input logic [15:0] n);
        exp_q.delete();
        init_q.delete();
        beat_idx   = 0;
        nop_cnt    = 0;
        nonnop_cnt = 0;
        first_run_word = 32'hx;
        push_expected(s, n);
        @(posedge clk);
        #1;
        seed      = s;
        num_instr = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
    endtask

    task automatic wait_done(input int budget);
        while (!done && cyc < budget) tick();
        check("done_reached", done, 1);
        check("sb_beats_left", exp_q.size(), 0);
        check("sb_init_left", init_q.size(), 0);
        check("busy_at_done", busy, 0);
    endtask

    task automatic wait_issued(input logic [15:0] k, input int budget);
        while (issued_count != k && cyc < budget) tick();
        check("issued_reached", issued_count, k);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rf_init_we) begin
                check("valid_in_init", instr_valid, 0);
                if (init_q.size() == 0) begin
                    check("init_unexpected", 1, 0);
                end else begin
                    logic [36:0] e;
                    e = init_q.pop_front();
                    check("init_addr", rf_init_addr, e[36:32]);
                    check("init_data", rf_init_data, e[31:0]);
                    if (rf_init_addr < 5'd4) init_log[rf_init_addr[1:0]] = rf_init_data;
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    check("beat", instr, exp_q.pop_front());
                    check("opcode", instr[6:0], 7'h13);
                    if (beat_idx == W) first_run_word = instr;
                    if (instr == NOP) nop_cnt++;
                    else nonnop_cnt++;
                    beat_idx++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [31:0] held;
        reset       = 1'b1;
        start       = 1'b0;
        seed        = 32'h0;
        num_instr   = 16'h0;
        instr_ready = 1'b1;
        #12;
        check("rst_instr", instr, NOP);
        check("rst_valid", instr_valid, 0);
        check("rst_we", rf_init_we, 0);
        check("rst_addr", rf_init_addr, 0);
        check("rst_data", rf_init_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issued", issued_count, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Seed 0 maps to 1; length with ready high is 1 + INIT + W + n + D.
        start_run(32'h0, 16'd4);
        wait_done(500);
        check("run_len_44", cyc, 1 + INIT_LEN + W + 4 + D);
        check("issued_final", issued_count, 4);
`ifdef REGFILE_INIT_EN
        check("init_addr0", init_log[0], 32'h0000_0001);
        check("init_addr1", init_log[1], 32'h8020_0003);
        check("init_addr2", init_log[2], 32'hC030_0002);
`endif

        // Zero-length stream with a randomly throttled consumer.
        rnd_ready = 1'b1;
        start_run(32'hDEAD_BEEF, 16'd0);
        wait_done(1000);
        rnd_ready   = 1'b0;
        instr_ready = 1'b1;
        check("zero_nops", nop_cnt, W + D);
        check("zero_nonnop", nonnop_cnt, 0);
        check("zero_issued", issued_count, 0);
        check("zero_done", done, 1);

        // First RUN word built from a chosen LFSR value with funct3=5, then funct3=1.
        s = {12'hFFF, 5'h0A, 3'd5, 5'h03, 7'h55};
        for (int i = 0; i < INIT_LEN; i++) s = lfsr_prev(s);
        start_run(s, 16'd2);
        wait_done(500);
        check("f5_imm", first_run_word[31:20], 12'h41F);
        check("f5_funct3", first_run_word[14:12], 3'd5);
        check("f5_opcode", first_run_word[6:0], 7'h13);
        s = {12'hFFF, 5'h11, 3'd1, 5'h1F, 7'h2A};
        for (int i = 0; i < INIT_LEN; i++) s = lfsr_prev(s);
        start_run(s, 16'd2);
        wait_done(500);
        check("f1_imm", first_run_word[31:20], 12'h01F);
        check("f1_funct3", first_run_word[14:12], 3'd1);

        // Back-pressure mid-RUN: word and count freeze, then the stream resumes intact.
        start_run(32'h1234_5678, 16'd8);
        wait_issued(16'd2, 500);
        instr_ready = 1'b0;
        held = instr;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", instr, held);
            check("stall_issued", issued_count, 2);
            check("stall_valid", instr_valid, 1);
        end
        instr_ready = 1'b1;
        wait_done(500);
        check("stall_issued_final", issued_count, 8);

        // Asynchronous reset in the middle of RUN, then a clean rerun.
        start_run(32'h0BAD_F00D, 16'd8);
        wait_issued(16'd2, 500);
        #2;
        reset = 1'b1;
        #1;
        check("arst_instr", instr, NOP);
        check("arst_valid", instr_valid, 0);
        check("arst_we", rf_init_we, 0);
        check("arst_addr", rf_init_addr, 0);
        check("arst_data", rf_init_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_issued", issued_count, 0);
        @(negedge clk);
        reset = 1'b0;
        start_run(32'h0BAD_F00D, 16'd3);
        wait_done(500);
`ifdef REGFILE_INIT_EN
        check("rerun_addr0", init_log[0], 32'h0BAD_F00D);
`endif

        // A start pulse while busy must not relatch seed or length.
        start_run(32'hCAFE_0001, 16'd6);
        for (int i = 0; i < 9; i++) tick();
        seed      = 32'h5555_AAAA;
        num_instr = 16'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(500);
        check("busy_start_len", cyc, 1 + INIT_LEN + W + 6 + D);
        check("busy_start_issued", issued_count, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
